// File: rtl/dcache_wb_buffer_if.sv
// Bus bundle for the data-cache write-back buffer: cache-side evict/fill
// handshakes, the shared memory port, and the wb_empty status flag.
interface dcache_wb_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              evict_valid;
  logic [ADDR_W-1:0] evict_addr;
  logic [DATA_W-1:0] evict_data;
  logic              evict_ready;
  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_valid;
  logic [DATA_W-1:0] fill_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_empty;

  // buffer side
  modport slave (
    input  evict_valid, evict_addr, evict_data, fill_req, fill_addr, mem_ack, mem_rdata,
    output evict_ready, fill_valid, fill_data, mem_req, mem_we, mem_addr, mem_wdata, wb_empty
  );

  // cache + memory side
  modport master (
    output evict_valid, evict_addr, evict_data, fill_req, fill_addr, mem_ack, mem_rdata,
    input  evict_ready, fill_valid, fill_data, mem_req, mem_we, mem_addr, mem_wdata, wb_empty
  );
endinterface

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer and miss port below the data cache. Queues dirty victims,
// drains them to memory, and serves read-miss fills (forwarded from the queue
// on an address hit, otherwise read from memory) over one shared memory port.
// Optional feature macro: DCACHE_WB_COALESCE_EN (evictions hitting a queued
// address overwrite that entry in place instead of allocating).
module dcache_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  dcache_wb_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              fill_valid_q, fill_valid_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              full, push, pop, coal_hit;

  assign full = (count_q == FULL);

  // Forward search over valid entries, oldest to youngest; the last hit wins.
  // Uses registered queue state only, so a same-cycle eviction is not seen.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < count_q && addr_q[rd_ptr_q + PW'(k)] == bus.fill_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[rd_ptr_q + PW'(k)];
      end
    end
  end

  // Port FSM: fills take priority over drains unless the queue is full.
  // fill_valid_q blocks re-triggering on the fill_req still held during the pulse.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fill_data_d  = fill_data_q;
    fill_valid_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fill_req && !fill_valid_q && fwd_hit) begin
          state_d     = RESP;
          fill_data_d = fwd_data;
        end else if (bus.fill_req && !fill_valid_q && !full) begin
          state_d     = READ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.fill_addr;
          mem_wdata_d = '0;
        end else if (count_q != '0) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q[rd_ptr_q];
          mem_wdata_d = data_q[rd_ptr_q];
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      READ: begin
        if (bus.mem_ack) begin
          fill_data_d = bus.mem_rdata;
          mem_req_d   = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        fill_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_WB_COALESCE_EN
  logic [PW-1:0] coal_idx;
  logic          head_busy;

  // The head is off-limits once its write data is latched (entering or in WRITE).
  assign head_busy = (state_q == WRITE) || (state_d == WRITE);

  // Youngest queued entry matching the victim address, head excluded while busy.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < count_q && addr_q[rd_ptr_q + PW'(k)] == bus.evict_addr &&
          !(k == 0 && head_busy)) begin
        coal_hit = 1'b1;
        coal_idx = rd_ptr_q + PW'(k);
      end
    end
  end

  // Coalesced victim overwrites the matching entry's data in place.
  always_ff @(posedge clk) begin
    if (bus.evict_valid && coal_hit) data_q[coal_idx] <= bus.evict_data;
    else if (push)                   data_q[wr_ptr_q] <= bus.evict_data;
  end
`else
  assign coal_hit = 1'b0;

  // Queue data storage; validity is tracked by count, so no reset.
  always_ff @(posedge clk) begin
    if (push) data_q[wr_ptr_q] <= bus.evict_data;
  end
`endif

  assign push    = bus.evict_valid && bus.evict_ready && !coal_hit;
  assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

  // Queue address storage.
  always_ff @(posedge clk) begin
    if (push) addr_q[wr_ptr_q] <= bus.evict_addr;
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_valid_q <= fill_valid_d;
      fill_data_q  <= fill_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign bus.evict_ready = !full || coal_hit;
  assign bus.fill_valid  = fill_valid_q;
  assign bus.fill_data   = fill_data_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.wb_empty    = (count_q == '0) && (state_q == IDLE);
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer: directed scenarios followed by a
// randomized evict/fill mix checked against a per-address "latest value" model
// and a FIFO of expected drain writes. A memory responder model answers the port.
module tb_dcache_wb_buffer;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dcache_wb_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  dcache_wb_buffer #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          ack_en  = 1'b0;
  int          ack_dly = 0;
  int          ack_cyc = -1;
  int          rd_cnt  = 0;
  bit          chk_wr  = 1'b0;
  logic [31:0] mem_m  [logic [31:0]];
  logic [31:0] latest [logic [31:0]];
  logic [63:0] exp_wr [$];
  logic [31:0] wlog_a [$];
  logic [31:0] wlog_d [$];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: acks after ack_dly waiting cycles, one-cycle pulse.
  initial begin
    int wc;
    logic [63:0] e;
    wc = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (reset || !bus.mem_req) wc = 0;
      else if (ack_en) begin
        if (wc >= ack_dly) begin
          bus.mem_ack = 1'b1;
          wc = 0;
          ack_cyc = cyc;
          if (bus.mem_we) begin
            mem_m[bus.mem_addr] = bus.mem_wdata;
            wlog_a.push_back(bus.mem_addr);
            wlog_d.push_back(bus.mem_wdata);
            if (chk_wr) begin
              e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 64'hx;
              chk("drain_order", {bus.mem_addr, bus.mem_wdata}, e);
            end
          end else begin
            bus.mem_rdata = mem_rd(bus.mem_addr);
            rd_cnt++;
          end
        end else wc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic evict(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    bus.evict_valid = 1'b1;
    bus.evict_addr  = a;
    bus.evict_data  = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.evict_ready) ok = 1'b1;
      tick();
    end
    bus.evict_valid = 1'b0;
    chk($sformatf("evict_accept_%0h", a), ok, 1);
    if (ok) begin
      latest[a] = d;
      if (chk_wr) exp_wr.push_back({a, d});
    end
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 400 && !bus.wb_empty; i++) tick();
    chk(tag, bus.wb_empty, 1);
  endtask

  task automatic wait_mem_req(input string tag);
    for (int i = 0; i < 50 && !bus.mem_req; i++) tick();
    chk(tag, bus.mem_req, 1);
  endtask

  // fill_req must already be driven; returns data and the cycle fill_valid was seen.
  task automatic wait_fill(input string tag, output logic [31:0] d, output int vc);
    bit got;
    got = 1'b0;
    d   = 'x;
    vc  = -1;
    for (int i = 0; i < 400; i++) begin
      if (bus.fill_valid) begin
        got = 1'b1;
        d   = bus.fill_data;
        vc  = cyc;
        break;
      end
      tick();
    end
    bus.fill_req = 1'b0;
    chk(tag, got, 1);
  endtask

  initial begin
    logic [31:0] d, a;
    int vc, r0, seen;
    bus.evict_valid = 1'b0;
    bus.evict_addr  = '0;
    bus.evict_data  = '0;
    bus.fill_req    = 1'b0;
    bus.fill_addr   = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_evict_ready", bus.evict_ready, 1);
    chk("rst_wb_empty",    bus.wb_empty,    1);
    chk("rst_mem_req",     bus.mem_req,     0);
    chk("rst_mem_we",      bus.mem_we,      0);
    chk("rst_fill_valid",  bus.fill_valid,  0);
    chk("rst_fill_data",   bus.fill_data,   0);

    // 1: single eviction drained with a slow ack
    ack_en = 1'b1; ack_dly = 3;
    evict(32'h100, 32'hAAAA);
    wait_mem_req("t1_mem_req");
    chk("t1_mem_we",    bus.mem_we,    1);
    chk("t1_mem_addr",  bus.mem_addr,  32'h100);
    chk("t1_mem_wdata", bus.mem_wdata, 32'hAAAA);
    wait_empty("t1_empty");
    chk("t1_mem_content", mem_rd(32'h100), 32'hAAAA);

    // 2: fill the queue with memory stalled; fifth eviction waits for first ack
    ack_en = 1'b0;
    wlog_a.delete(); wlog_d.delete();
    for (int i = 0; i < 4; i++) evict(32'h10 + 32'(4*i), 32'h1000 + 32'(i));
    chk("t2_full_ready", bus.evict_ready, 0);
    bus.evict_valid = 1'b1; bus.evict_addr = 32'h20; bus.evict_data = 32'h1004;
    repeat (3) tick();
    chk("t2_stall_ready", bus.evict_ready, 0);
    chk("t2_no_writes", wlog_a.size(), 0);
    ack_en = 1'b1; ack_dly = 0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.evict_ready) begin seen = 1; tick(); break; end
      tick();
    end
    bus.evict_valid = 1'b0;
    chk("t2_fifth_accept", seen, 1);
    chk("t2_after_first_ack", wlog_a.size() > 0, 1);
    wait_empty("t2_empty");
    chk("t2_nwrites", wlog_a.size(), 5);
    for (int i = 0; i < 5 && i < wlog_a.size(); i++) begin
      chk($sformatf("t2_wr%0d_addr", i), wlog_a[i], 32'h10 + 32'(4*i));
      chk($sformatf("t2_wr%0d_data", i), wlog_d[i], 32'h1000 + 32'(i));
    end

    // 3: duplicate address queued twice; fill forwards the younger copy
    ack_dly = 4;
    evict(32'h200, 32'h11);
    evict(32'h200, 32'h22);
    r0 = rd_cnt;
    bus.fill_addr = 32'h200; bus.fill_req = 1'b1;
    wait_fill("t3_fill", d, vc);
    chk("t3_fill_data", d, 32'h22);
    chk("t3_no_mem_read", rd_cnt - r0, 0);
    wait_empty("t3_empty");
    chk("t3_mem_final", mem_rd(32'h200), 32'h22);

    // 4: miss to a non-queued address is read before the pending drain
    mem_m[32'h300] = 32'hBEEF;
    ack_dly = 2;
    wlog_a.delete(); wlog_d.delete();
    r0 = rd_cnt;
    bus.fill_addr = 32'h300; bus.fill_req = 1'b1;
    bus.evict_valid = 1'b1; bus.evict_addr = 32'h100; bus.evict_data = 32'h5555;
    tick();
    bus.evict_valid = 1'b0;
    wait_mem_req("t4_mem_req");
    chk("t4_read_first", bus.mem_we, 0);
    chk("t4_read_addr", bus.mem_addr, 32'h300);
    wait_fill("t4_fill", d, vc);
    chk("t4_fill_data", d, 32'hBEEF);
    chk("t4_latency", vc - ack_cyc, 2);
    tick();
    chk("t4_pulse_one_cycle", bus.fill_valid, 0);
    wait_empty("t4_empty");
    chk("t4_one_read", rd_cnt - r0, 1);
    chk("t4_drain_addr", (wlog_a.size() > 0) ? wlog_a[0] : 32'hx, 32'h100);
    chk("t4_drain_data", (wlog_d.size() > 0) ? wlog_d[0] : 32'hx, 32'h5555);

    // 5: reset while a write is outstanding discards everything
    ack_en = 1'b0;
    evict(32'h400, 32'h1);
    evict(32'h404, 32'h2);
    wait_mem_req("t5_mem_req");
    chk("t5_mem_we", bus.mem_we, 1);
    reset = 1'b1;
    tick();
    chk("t5_req_drop", bus.mem_req, 0);
    chk("t5_ready", bus.evict_ready, 1);
    chk("t5_empty", bus.wb_empty, 1);
    reset = 1'b0;
    ack_en = 1'b1; ack_dly = 0;
    seen = 0;
    repeat (10) begin tick(); if (bus.mem_req) seen++; end
    chk("t5_queue_discarded", seen, 0);

`ifdef DCACHE_WB_COALESCE_EN
    // 6: coalescing into a non-head entry of a full queue
    ack_en = 1'b0;
    wlog_a.delete(); wlog_d.delete();
    for (int i = 0; i < 4; i++) evict(32'h10 + 32'(4*i), 32'h60 + 32'(i));
    bus.evict_addr = 32'h30;
    #1;
    chk("t6_full_nomatch", bus.evict_ready, 0);
    bus.evict_addr = 32'h10; bus.evict_data = 32'h99;
    #1;
    chk("t6_head_busy", bus.evict_ready, 0);
    bus.evict_addr = 32'h14; bus.evict_data = 32'h55; bus.evict_valid = 1'b1;
    #1;
    chk("t6_coalesce_ready", bus.evict_ready, 1);
    tick();
    bus.evict_valid = 1'b0; bus.evict_addr = 32'h30;
    #1;
    chk("t6_count_unchanged", bus.evict_ready, 0);
    ack_en = 1'b1; ack_dly = 0;
    wait_empty("t6_empty");
    chk("t6_nwrites", wlog_a.size(), 4);
    chk("t6_wr1_addr", (wlog_a.size() > 1) ? wlog_a[1] : 32'hx, 32'h14);
    chk("t6_wr1_data", (wlog_d.size() > 1) ? wlog_d[1] : 32'hx, 32'h55);
    chk("t6_wr0_data", (wlog_d.size() > 0) ? wlog_d[0] : 32'hx, 32'h60);
`endif

    // Random mix over a small address pool
    latest.delete();
    exp_wr.delete();
`ifndef DCACHE_WB_COALESCE_EN
    chk_wr = 1'b1;
`endif
    ack_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      ack_dly = $urandom_range(0, 3);
      a = 32'h800 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        evict(a, $urandom);
      end else begin
        logic [31:0] e;
        e = latest.exists(a) ? latest[a] : init_val(a);
        bus.fill_addr = a; bus.fill_req = 1'b1;
        wait_fill($sformatf("rnd_fill_%0d", n), d, vc);
        chk($sformatf("rnd_fill_data_%0d_%0h", n, a), d, e);
        tick();
      end
    end
    wait_empty("rnd_empty");
    chk("rnd_all_drained", exp_wr.size(), 0);
    foreach (latest[k]) chk($sformatf("rnd_mem_%0h", k), mem_rd(k), latest[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
